mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - arbitrated single-port memory access for fetch and load/store
// Optional store protection of the instruction region: define MEM_WPROT_EN.
module mem_access_ctrl #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-2:0] if_pc,
  output logic          if_ack,
  output logic [DW-1:0] if_inst,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_ack,
  output logic [DW-1:0] ls_rdata,
  output logic          ls_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_w_en,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_last_fetch;   // 1 when the most recent grant went to the fetch port
  logic          r_is_fetch;
  logic          r_is_store;
  logic          r_blocked;      // latched store that protection refused
  logic [AW-1:0] r_mem_addr;
  logic          r_mem_w_en;
  logic [DW-1:0] r_mem_wdata;
  logic          r_if_ack;
  logic          r_ls_ack;
  logic          r_ls_err;
  logic [DW-1:0] r_if_inst;
  logic [DW-1:0] r_ls_rdata;
  logic          r_busy;

  logic          w_grant_ls;
  logic          w_grant_if;
  logic          w_store_blocked;

`ifdef MEM_WPROT_EN
  // Lower half of the address space holds instructions and is read-only for stores
  assign w_store_blocked = ls_we && !ls_addr[AW-1];
`else
  assign w_store_blocked = 1'b0;
`endif

  // Alternating-priority arbitration: on contention the side not served last wins
  always_comb begin
    w_grant_ls = 1'b0;
    w_grant_if = 1'b0;
    if (ls_req && (!if_req || r_last_fetch)) begin
      w_grant_ls = 1'b1;
    end else if (if_req) begin
      w_grant_if = 1'b1;
    end
  end

  // Controller FSM: IDLE grants and latches, ACCESS drives memory, RESP acks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_last_fetch <= 1'b1;
      r_is_fetch   <= 1'b0;
      r_is_store   <= 1'b0;
      r_blocked    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_w_en   <= 1'b0;
      r_mem_wdata  <= '0;
      r_if_ack     <= 1'b0;
      r_ls_ack     <= 1'b0;
      r_ls_err     <= 1'b0;
      r_if_inst    <= '0;
      r_ls_rdata   <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_if_ack <= 1'b0;
          r_ls_ack <= 1'b0;
          r_ls_err <= 1'b0;
          if (w_grant_ls) begin
            r_state      <= S_ACCESS;
            r_busy       <= 1'b1;
            r_last_fetch <= 1'b0;
            r_is_fetch   <= 1'b0;
            r_is_store   <= ls_we;
            r_blocked    <= w_store_blocked;
            r_mem_addr   <= ls_addr;
            r_mem_w_en   <= ls_we && !w_store_blocked;
            r_mem_wdata  <= ls_we ? ls_wdata : '0;
          end else if (w_grant_if) begin
            r_state      <= S_ACCESS;
            r_busy       <= 1'b1;
            r_last_fetch <= 1'b1;
            r_is_fetch   <= 1'b1;
            r_is_store   <= 1'b0;
            r_blocked    <= 1'b0;
            r_mem_addr   <= {1'b0, if_pc};
            r_mem_w_en   <= 1'b0;
            r_mem_wdata  <= '0;
          end
        end
        S_ACCESS: begin
          r_state     <= S_RESP;
          r_mem_addr  <= '0;
          r_mem_w_en  <= 1'b0;
          r_mem_wdata <= '0;
          if (r_is_fetch) begin
            r_if_inst <= mem_rdata;
            r_if_ack  <= 1'b1;
          end else begin
            r_ls_ack <= 1'b1;
            r_ls_err <= r_blocked;
            if (!r_is_store) begin
              r_ls_rdata <= mem_rdata;
            end
          end
        end
        S_RESP: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_if_ack <= 1'b0;
          r_ls_ack <= 1'b0;
          r_ls_err <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_w_en  <= 1'b0;
          r_mem_wdata <= '0;
          r_if_ack    <= 1'b0;
          r_ls_ack    <= 1'b0;
          r_ls_err    <= 1'b0;
        end
      endcase
    end
  end

  assign if_ack    = r_if_ack;
  assign if_inst   = r_if_inst;
  assign ls_ack    = r_ls_ack;
  assign ls_rdata  = r_ls_rdata;
  assign ls_err    = r_ls_err;
  assign mem_addr  = r_mem_addr;
  assign mem_w_en  = r_mem_w_en;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule
